// File: rtl/ptw_axi_read_arbiter.sv
// ptw_axi_read_arbiter: round-robin ITLB/DTLB page-table-walk reads onto one single-beat AXI4 read port
module ptw_axi_read_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int I_ID           = 0,
  parameter int D_ID           = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  I_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic                  I_DATA_VALID,
  output logic [DATA_WIDTH-1:0] I_DATA,
  output logic                  I_ACCESS_FAULT,
  input  logic                  D_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  output logic                  D_DATA_VALID,
  output logic [DATA_WIDTH-1:0] D_DATA,
  output logic                  D_ACCESS_FAULT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic [ID_WIDTH-1:0]   M_RID,
  output logic                  BUSY
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  typedef enum logic [1:0] {IDLE, AR, R_WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic i_pend, d_pend, rr_d, gnt_d, contend, grant, rsp, tmo, pick_d, done;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q, gaddr;
  logic [CW-1:0] cnt;
  assign pick_d = d_pend & (~i_pend | rr_d);
  assign gaddr = pick_d ? d_addr_q : i_addr_q;
  assign done = rsp | tmo;
  assign M_ARLEN = 8'd0;
  assign M_ARSIZE = 3'd3;
  assign M_ARBURST = 2'd1;
  assign BUSY = (state != IDLE) | i_pend | d_pend;
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_nx;
  // next state and AXI handshake outputs
  always_comb begin
    state_nx = state;
    M_ARVALID = 1'b0;
    M_RREADY = 1'b0;
    grant = 1'b0;
    rsp = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        grant = i_pend | d_pend;
        state_nx = grant ? AR : IDLE;
      end
      AR: begin
        M_ARVALID = 1'b1;
        state_nx = M_ARREADY ? R_WAIT : AR;
      end
      R_WAIT: begin
        M_RREADY = 1'b1;
        rsp = M_RVALID;
        tmo = TO_EN && !M_RVALID && cnt == TO_LAST;
        state_nx = rsp ? IDLE : tmo ? DRAIN : R_WAIT;
      end
      default: begin
        M_RREADY = 1'b1;
        state_nx = M_RVALID ? IDLE : DRAIN;
      end
    endcase
  end
  // client capture (a new pulse wins over the grant clear), grant payload, timeout count
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      i_pend <= 1'b0;
      d_pend <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      M_ARADDR <= '0;
      M_ARID <= '0;
      gnt_d <= 1'b0;
      contend <= 1'b0;
      cnt <= '0;
    end else begin
      i_pend <= I_ADDR_VALID | (i_pend & ~(grant & ~pick_d));
      d_pend <= D_ADDR_VALID | (d_pend & ~(grant & pick_d));
      if (I_ADDR_VALID) i_addr_q <= I_ADDR;
      if (D_ADDR_VALID) d_addr_q <= D_ADDR;
      if (grant) begin
        M_ARADDR <= {gaddr[ADDR_WIDTH-1:3], 3'b0};
        M_ARID <= pick_d ? ID_WIDTH'(D_ID) : ID_WIDTH'(I_ID);
        gnt_d <= pick_d;
        contend <= i_pend & d_pend;
      end
      cnt <= state == R_WAIT ? cnt + 1'b1 : '0;
    end
  // response pulse to the granted walker; rr pointer moves only after a contested grant
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      I_DATA_VALID <= 1'b0;
      D_DATA_VALID <= 1'b0;
      I_DATA <= '0;
      D_DATA <= '0;
      I_ACCESS_FAULT <= 1'b0;
      D_ACCESS_FAULT <= 1'b0;
      rr_d <= 1'b0;
    end else begin
      I_DATA_VALID <= done & ~gnt_d;
      D_DATA_VALID <= done & gnt_d;
      if (done & ~gnt_d) begin
        I_DATA <= rsp ? M_RDATA : '0;
        I_ACCESS_FAULT <= tmo | (|M_RRESP) | (M_RID != M_ARID);
      end
      if (done & gnt_d) begin
        D_DATA <= rsp ? M_RDATA : '0;
        D_ACCESS_FAULT <= tmo | (|M_RRESP) | (M_RID != M_ARID);
      end
      if (done & contend) rr_d <= ~gnt_d;
    end
endmodule

// File: tb/tb_ptw_axi_read_arbiter.sv
// tb_ptw_axi_read_arbiter: directed checks of the PTW read arbiter
module tb_ptw_axi_read_arbiter;
  logic CLK = 0, RST = 1;
  logic I_ADDR_VALID = 0, D_ADDR_VALID = 0;
  logic [63:0] I_ADDR = 0, D_ADDR = 0;
  logic I_DATA_VALID, D_DATA_VALID, I_ACCESS_FAULT, D_ACCESS_FAULT;
  logic [63:0] I_DATA, D_DATA;
  logic M_ARVALID, M_ARREADY = 0, M_RVALID = 0, M_RREADY, BUSY;
  logic [63:0] M_ARADDR, M_RDATA = 0;
  logic [3:0] M_ARID, M_RID = 0;
  logic [7:0] M_ARLEN;
  logic [2:0] M_ARSIZE;
  logic [1:0] M_ARBURST, M_RRESP = 0;
  int total = 0, bad = 0;
  ptw_axi_read_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .I_ADDR_VALID(I_ADDR_VALID), .I_ADDR(I_ADDR), .I_DATA_VALID(I_DATA_VALID),
    .I_DATA(I_DATA), .I_ACCESS_FAULT(I_ACCESS_FAULT),
    .D_ADDR_VALID(D_ADDR_VALID), .D_ADDR(D_ADDR), .D_DATA_VALID(D_DATA_VALID),
    .D_DATA(D_DATA), .D_ACCESS_FAULT(D_ACCESS_FAULT),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RID(M_RID), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input bit d, input logic [63:0] a);
    @(negedge CLK);
    if (d) begin D_ADDR_VALID = 1; D_ADDR = a; end
    else begin I_ADDR_VALID = 1; I_ADDR = a; end
    @(negedge CLK);
    I_ADDR_VALID = 0;
    D_ADDR_VALID = 0;
  endtask
  task automatic wait_ar();
    for (int k = 0; k < 50 && !M_ARVALID; k++) @(negedge CLK);
    chk("arvalid_seen", M_ARVALID, 1);
  endtask
  task automatic serve(input logic [63:0] addr, input logic [3:0] id, input logic [63:0] data,
                       input logic [1:0] resp, input logic [3:0] rid, input bit to_d, input bit flt);
    wait_ar();
    chk("araddr", M_ARADDR, addr);
    chk("arid", M_ARID, id);
    M_ARREADY = 1;
    @(negedge CLK);
    M_ARREADY = 0;
    chk("arvalid_drop", M_ARVALID, 0);
    chk("rready", M_RREADY, 1);
    M_RVALID = 1; M_RDATA = data; M_RRESP = resp; M_RID = rid;
    @(negedge CLK);
    M_RVALID = 0;
    chk("i_dv", I_DATA_VALID, !to_d);
    chk("d_dv", D_DATA_VALID, to_d);
    chk("rsp_data", to_d ? D_DATA : I_DATA, data);
    chk("rsp_fault", to_d ? D_ACCESS_FAULT : I_ACCESS_FAULT, flt);
    @(negedge CLK);
    chk("dv_one_cycle", I_DATA_VALID | D_DATA_VALID, 0);
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    RST = 0;
    chk("rst_arvalid", M_ARVALID, 0);
    chk("rst_rready", M_RREADY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_dv", I_DATA_VALID | D_DATA_VALID, 0);
    chk("arlen", M_ARLEN, 0);
    chk("arsize", M_ARSIZE, 3);
    chk("arburst", M_ARBURST, 1);
    // DTLB single request, minimum latency
    pulse(1, 64'h8000_1238);
    chk("lat_c1", M_ARVALID, 0);
    @(negedge CLK);
    chk("lat_c2", M_ARVALID, 1);
    serve(64'h8000_1238, 1, 64'h2000_00CF, 0, 1, 1, 0);
    // simultaneous pairs: ITLB first, then DTLB first
    @(negedge CLK);
    I_ADDR_VALID = 1; I_ADDR = 64'h1000; D_ADDR_VALID = 1; D_ADDR = 64'h2008;
    @(negedge CLK);
    I_ADDR_VALID = 0; D_ADDR_VALID = 0;
    serve(64'h1000, 0, 64'h11, 0, 0, 0, 0);
    serve(64'h2008, 1, 64'h22, 0, 1, 1, 0);
    @(negedge CLK);
    I_ADDR_VALID = 1; I_ADDR = 64'h3100; D_ADDR_VALID = 1; D_ADDR = 64'h4200;
    @(negedge CLK);
    I_ADDR_VALID = 0; D_ADDR_VALID = 0;
    serve(64'h4200, 1, 64'h33, 0, 1, 1, 0);
    serve(64'h3100, 0, 64'h44, 0, 0, 0, 0);
    // ARREADY stalled, low address bits forced, then RRESP error
    pulse(0, 64'h3007);
    wait_ar();
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("stall_arvalid", M_ARVALID, 1);
      chk("stall_araddr", M_ARADDR, 64'h3000);
      chk("stall_no_dv", I_DATA_VALID | D_DATA_VALID, 0);
    end
    serve(64'h3000, 0, 64'h55AA, 2'b10, 0, 0, 1);
    // RID mismatch faults; ITLB response registers hold
    pulse(1, 64'h7777_0010);
    serve(64'h7777_0010, 1, 64'h66, 0, 4'd5, 1, 1);
    chk("hold_i_data", I_DATA, 64'h55AA);
    chk("hold_i_fault", I_ACCESS_FAULT, 1);
    // timeout then silent drain
    pulse(0, 64'h9000);
    wait_ar();
    M_ARREADY = 1;
    @(negedge CLK);
    M_ARREADY = 0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge CLK);
      chk("to_early", I_DATA_VALID | D_DATA_VALID, 0);
    end
    @(negedge CLK);
    chk("to_dv", I_DATA_VALID, 1);
    chk("to_fault", I_ACCESS_FAULT, 1);
    chk("to_data", I_DATA, 0);
    chk("to_d_quiet", D_DATA_VALID, 0);
    @(negedge CLK);
    chk("drain_busy", BUSY, 1);
    chk("drain_rready", M_RREADY, 1);
    M_RVALID = 1; M_RDATA = 64'hDEAD; M_RRESP = 0; M_RID = 0;
    @(negedge CLK);
    M_RVALID = 0;
    chk("drain_silent", I_DATA_VALID | D_DATA_VALID, 0);
    chk("drain_idle", BUSY, 0);
    chk("drain_data_held", I_DATA, 0);
    // reset in the middle of R_WAIT with an ITLB request pending
    pulse(1, 64'h5000);
    wait_ar();
    M_ARREADY = 1;
    @(negedge CLK);
    M_ARREADY = 0;
    pulse(0, 64'h6000);
    chk("pre_rst_busy", BUSY, 1);
    #2 RST = 1;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_rready", M_RREADY, 0);
    chk("mid_rst_arvalid", M_ARVALID, 0);
    chk("mid_rst_data", I_DATA | D_DATA, 0);
    chk("mid_rst_fault", I_ACCESS_FAULT | D_ACCESS_FAULT, 0);
    chk("mid_rst_araddr", M_ARADDR, 0);
    @(negedge CLK);
    RST = 0;
    M_RVALID = 1; M_RDATA = 64'hBEEF; M_RID = 1;
    @(negedge CLK);
    M_RVALID = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("post_rst_no_dv", I_DATA_VALID | D_DATA_VALID, 0);
      chk("post_rst_no_ar", M_ARVALID, 0);
    end
    chk("post_rst_idle", BUSY, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
